wc_tile_sched: RTL

//  Tile scheduler for the F(6,3) Winograd core WC (80-bit D = 8x10-bit input tile, 60-bit Z = 6x10-bit outputs).

---
 rtl/wc_tile_sched_pkg.sv | 28 ++
 rtl/wc_tile_sched_if.sv | 30 +++
 rtl/wc_tile_sched_res_fifo.sv | 83 ++++++++
 rtl/wc_tile_sched.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/wc_tile_sched_pkg.sv
// Shared constants and types for the Winograd F(6,3) tile scheduler.
//   TILE_N  samples per WC input tile
//   OUT_N   outputs per tile, which is also the tile stride
//   OVERLAP samples carried from one tile into the next
//   SAMP_W  sample/output width
`timescale 1ns/1ps
package wc_tile_sched_pkg;

  localparam int unsigned TILE_N  = 8;
  localparam int unsigned OUT_N   = 6;
  localparam int unsigned OVERLAP = 2;
  localparam int unsigned SAMP_W  = 10;
  localparam int unsigned TILE_W  = TILE_N * SAMP_W;  // wc_D width
  localparam int unsigned RES_W   = OUT_N * SAMP_W;   // wc_Z / m_data width

  typedef enum logic [1:0] {
    StFillFirst,
    StFill,
    StIssue
  } state_e;

  // One stage of the WC latency tracker.
  typedef struct packed {
    logic vld;
    logic last;
  } tag_t;

endpackage

// File: rtl/wc_tile_sched_if.sv
// Bus bundle for wc_tile_sched: input sample stream (s_*), WC core tile/result
// (wc_D out, wc_Z in) and output result stream (m_*).
//   slave  : scheduler view (consumes s_*, drives wc_D and m_*)
//   master : environment view (drives s_*, wc_Z, m_ready)
`timescale 1ns/1ps
interface wc_tile_sched_if;
  import wc_tile_sched_pkg::*;

  logic              s_valid;
  logic              s_ready;
  logic [SAMP_W-1:0] s_data;
  logic              s_last;
  logic [TILE_W-1:0] wc_D;
  logic [RES_W-1:0]  wc_Z;
  logic              m_valid;
  logic              m_ready;
  logic [RES_W-1:0]  m_data;
  logic              m_last;

  modport slave (
    input  s_valid, s_data, s_last, wc_Z, m_ready,
    output s_ready, wc_D, m_valid, m_data, m_last
  );

  modport master (
    output s_valid, s_data, s_last, wc_Z, m_ready,
    input  s_ready, wc_D, m_valid, m_data, m_last
  );

endinterface

// File: rtl/wc_tile_sched_res_fifo.sv
// wc_res_fifo: synchronous first-word-fall-through result FIFO.
//   clk, rst  clock, asynchronous active-high reset
//   push_i    write wdata_i (ignored only if full without a same-cycle pop)
//   pop_i     consume head entry (ignored when empty)
//   rdata_o   head entry, valid whenever empty_o is low
//   empty_o, full_o, count_o  occupancy status
`timescale 1ns/1ps
module wc_res_fifo #(
  parameter int unsigned Width = 61,
  parameter int unsigned Depth = 4,
  localparam int unsigned CntW = $clog2(Depth + 1),
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic            pop_i,
  output logic [Width-1:0] rdata_o,
  output logic            empty_o,
  output logic            full_o,
  output logic [CntW-1:0] count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop frees the head slot this cycle, so push on full is fine alongside it.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_i && full_o && !pop_i));

endmodule

// File: rtl/wc_tile_sched.sv
// wc_tile_sched: cuts a valid/ready sample stream into overlapping 8-sample
// tiles (stride 6) for the Winograd core, tracks the core's fixed latency with
// a tag shift register and buffers results in a FIFO. Issue is credit-gated so
// no core result can ever find the FIFO full.
//   clk, rst   clock, asynchronous active-high reset
//   bus        wc_tile_sched_if.slave: s_* input stream, wc_D/wc_Z core
//              tile/result, m_* result stream
// Parameters: WC_LAT issue-to-result cycles (>=1), FIFO_DEPTH result entries.
`timescale 1ns/1ps
module wc_tile_sched
  import wc_tile_sched_pkg::*;
#(
  parameter int unsigned WC_LAT     = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  wc_tile_sched_if.slave  bus
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [SAMP_W-1:0] win_q [TILE_N];
  logic [SAMP_W-1:0] win_d [TILE_N];
  logic              last_pend_q, last_pend_d;
  logic [TILE_W-1:0] wc_d_q, wc_d_d;
  tag_t              tag_q [WC_LAT];
  tag_t              tag_d [WC_LAT];

  logic              accept, issue, credit_ok;
  logic [CntW-1:0]   inflight, fifo_count;
  logic              fifo_empty, fifo_full;
  logic [RES_W:0]    fifo_rdata;

  assign bus.s_ready = (state_q != StIssue) & ~rst;
  assign accept      = bus.s_valid & bus.s_ready;
  assign bus.wc_D    = wc_d_q;

  // Results already buffered plus results still inside the core must leave
  // room for one more tile.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < WC_LAT; i++) begin
      inflight = inflight + CntW'(tag_q[i].vld);
    end
  end
  assign credit_ok = ({1'b0, fifo_count} + {1'b0, inflight}) < (CntW + 1)'(FIFO_DEPTH);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    win_d       = win_q;
    last_pend_d = last_pend_q;
    wc_d_d      = wc_d_q;
    issue       = 1'b0;
    unique case (state_q)
      StFillFirst, StFill: begin
        // Slots at and above cnt are always zero here, so a short final tile
        // is zero-filled without extra work.
        if (accept) begin
          win_d[cnt_q[2:0]] = bus.s_data;
          cnt_d             = cnt_q + 4'd1;
          if (bus.s_last) begin
            last_pend_d = 1'b1;
            state_d     = StIssue;
          end else if (cnt_q == 4'(TILE_N - 1)) begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (credit_ok) begin
          issue       = 1'b1;
          last_pend_d = 1'b0;
          for (int k = 0; k < TILE_N; k++) begin
            wc_d_d[k*SAMP_W +: SAMP_W] = win_q[k];
            win_d[k]                   = '0;
          end
          if (last_pend_q) begin
            cnt_d   = '0;
            state_d = StFillFirst;
          end else begin
            for (int k = 0; k < OVERLAP; k++) begin
              win_d[k] = win_q[k + OUT_N];
            end
            cnt_d   = 4'(OVERLAP);
            state_d = StFill;
          end
        end
      end
      default: state_d = StFillFirst;
    endcase
  end

  always_comb begin
    tag_d[0] = '{vld: issue, last: issue & last_pend_q};
    for (int i = 1; i < WC_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StFillFirst;
      cnt_q       <= '0;
      win_q       <= '{default: '0};
      last_pend_q <= 1'b0;
      wc_d_q      <= '0;
      tag_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      win_q       <= win_d;
      last_pend_q <= last_pend_d;
      wc_d_q      <= wc_d_d;
      tag_q       <= tag_d;
    end
  end

  wc_res_fifo #(
    .Width (RES_W + 1),
    .Depth (FIFO_DEPTH)
  ) u_res_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tag_q[WC_LAT-1].vld),
    .wdata_i ({tag_q[WC_LAT-1].last, bus.wc_Z}),
    .pop_i   (bus.m_ready),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  assign bus.m_valid = ~fifo_empty;
  assign bus.m_data  = fifo_rdata[RES_W-1:0];
  assign bus.m_last  = fifo_rdata[RES_W] & ~fifo_empty;

endmodule
